alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised successor of the 8-bit combinational ALU top.
- Same 16-bit instruction format: dest[15:14], group[13:12], op[11:10]. Adds configurable width and output-bank count.
- Adds a valid/ready input handshake, registered output banks that hold their values, and a multi-cycle shift-add multiplier.
- Sits between the instruction/operand source and the display/bank consumers.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- NUM_OUT, 4, number of output banks (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  block can accept this cycle.
- instruction  in  16  [15:14] dest bank, [13:12] group, [11:10] op, [9:0] ignored.
- data0  in  WIDTH  operand A, unsigned.
- data1  in  WIDTH  operand B, unsigned.
- out_bank  out  NUM_OUT*WIDTH  bank k occupies bits [k*WIDTH +: WIDTH].
- res_valid  out  1  one-cycle pulse: a result was committed.
- of  out  1  overflow/carry flag of last committed result.
- zf  out  1  zero flag of last committed result.

Behaviour:
- Interface decisions: one clock; reset is synchronous and active-high.
- Reset: all banks 0, of=0, zf=0, res_valid=0, state IDLE, in_ready=1. Reset in any state, including mid-multiply, aborts the operation with no bank write.
- Accept: a transfer happens on a rising edge with in_valid && in_ready. instruction, data0 and data1 are sampled only at accept.
- States: IDLE (in_ready=1) and MUL (in_ready=0).
- Single-cycle ops:
  - Result is written to bank dest and of/zf update on the accept edge (E0).
  - res_valid is high for the one cycle after E0.
  - State stays IDLE, so back-to-back accepts are allowed.
- Group 00 (shift/arithmetic):
  - op00: data0 >> data1; op01: data0 << data1. data1 is taken as the full unsigned amount; amount >= WIDTH gives 0. of=0.
  - op10: data0 + data1, mod 2^WIDTH, of = carry out.
  - op11: data0 - data1, mod 2^WIDTH, of = borrow (data0 < data1).
- Group 01 (logic): op00 AND, op01 OR, op10 XOR, op11 constant 1. of=0.
- Group 11: result = {0..., (data0 < data1) unsigned}; op field ignored; of=0.
- Group 10 (multiply):
  - op00: low WIDTH bits of the product, of = (high half != 0).
  - op01: high WIDTH bits of the product, of=0.
  - op1x: reserved; single-cycle, result 0, of=0.
  - op0x goes to MUL and runs a shift-add over a 2*WIDTH product register, one bit per cycle, on edges E1..E_WIDTH.
  - At E_WIDTH: bank write, flag update, res_valid pulse next cycle, return to IDLE. in_ready is 0 from after E0 until after E_WIDTH.
- zf = (committed result == 0), for every op.
- Dest index >= NUM_OUT: no bank is written; of/zf and res_valid still update.
- Banks, of and zf hold their values between commits. res_valid is 0 except in the single cycle after a commit.
- in_valid while in_ready=0 is ignored; the source must hold or re-present the request.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: group 10 multiply as described, including state MUL.
- Undefined: no multiplier logic; in_ready is tied to 1; every group-10 op is single-cycle with result 0, of=0, zf=1.

Test Plan:
- Reset: assert rst 2 cycles, then release -> all banks 0x00, of=0, zf=0, res_valid=0, in_ready=1.
- Add (WIDTH=8): instr 0x8800, data0=0xF0, data1=0x20, one-cycle in_valid -> next cycle out_bank[2]=0x10, of=1, zf=0, res_valid=1 for exactly one cycle; other banks unchanged.
- Sub then shift, back-to-back:
  - instr 0x0C00, data0=0x05, data1=0x05 -> bank0=0x00, zf=1, of=0.
  - Next cycle instr 0xC400, data0=0xFF, data1=9 -> bank3=0x00, zf=1 (shift >= WIDTH).
  - Two res_valid pulses on consecutive cycles.
- Multiply lo: instr 0x6000, data0=0x12, data1=0x34, with in_valid held high throughout -> in_ready=0 for 8 cycles, then bank1=0xA8, of=1, zf=0. Only one commit results; the second accept occurs only once in_ready returns to 1.
- Multiply hi: instr 0x6400, data0=0xFF, data1=0xFF -> bank1=0xFE, of=0, after 8 busy cycles.
- Reset mid-multiply: start instr 0x6000, assert rst at busy cycle 4 -> banks/flags 0, no res_valid, in_ready=1 the cycle after reset releases. Then group 01 op11 to bank 0 -> bank0=0x01.

Source files
------------

// File: rtl/alu_seq.sv
// Registered, parametrised ALU with valid/ready input, held output banks and status flags.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier (group 10, op 00/01).
module alu_seq #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              instruction,
    input  logic [WIDTH-1:0]         data0,
    input  logic [WIDTH-1:0]         data1,
    output logic [NUM_OUT*WIDTH-1:0] out_bank,
    output logic                     res_valid,
    output logic                     of,
    output logic                     zf
);

    logic [1:0] group;
    logic [1:0] op;
    assign group = instruction[13:12];
    assign op    = instruction[11:10];

    logic unused_instr;
    assign unused_instr = ^instruction[9:0];

    logic             accept;
    logic             start_mul;
    logic [WIDTH-1:0] op_res;
    logic             op_of;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;

    logic             commit;
    logic [1:0]       c_dest;
    logic [WIDTH-1:0] c_res;
    logic             c_of;

    logic [WIDTH-1:0] bank_q [NUM_OUT];
    logic             of_q;
    logic             zf_q;
    logic             res_valid_q;

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {StIdle, StMul} state_e;

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mcand_q;
    logic [1:0]         mdest_q;
    logic               mhi_q;
    logic [WIDTH:0]     acc_sum;
    logic               mul_done;

    // prod_q holds {accumulator, remaining multiplier bits}; one bit retires per cycle.
    always_comb begin
        acc_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {acc_sum, prod_q[WIDTH-1:1]};
        mul_done  = (state_q == StMul) && (cnt_q == LastStep);
    end

    assign in_ready = (state_q == StIdle);
`else
    assign in_ready = 1'b1;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        op_res    = '0;
        op_of     = 1'b0;
        start_mul = 1'b0;
        add_sum   = {1'b0, data0} + {1'b0, data1};
        sub_diff  = {1'b0, data0} - {1'b0, data1};
        case (group)
            2'b00: begin
                case (op)
                    2'b00: op_res = data0 >> data1;
                    2'b01: op_res = data0 << data1;
                    2'b10: {op_of, op_res} = add_sum;
                    default: {op_of, op_res} = sub_diff;
                endcase
            end
            2'b01: begin
                case (op)
                    2'b00: op_res = data0 & data1;
                    2'b01: op_res = data0 | data1;
                    2'b10: op_res = data0 ^ data1;
                    default: op_res = WIDTH'(1);
                endcase
            end
            2'b10: begin
`ifdef ALU_MUL_EN
                start_mul = ~op[1];
`endif
                op_res = '0;
            end
            default: op_res = WIDTH'(data0 < data1);
        endcase
    end

    always_comb begin
        commit = accept && !start_mul;
        c_dest = instruction[15:14];
        c_res  = op_res;
        c_of   = op_of;
`ifdef ALU_MUL_EN
        if (mul_done) begin
            commit = 1'b1;
            c_dest = mdest_q;
            c_res  = mhi_q ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
            c_of   = !mhi_q && (|prod_step[2*WIDTH-1:WIDTH]);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_OUT; k++) bank_q[k] <= '0;
            of_q        <= 1'b0;
            zf_q        <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q <= StIdle;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            mdest_q <= '0;
            mhi_q   <= 1'b0;
`endif
        end else begin
            res_valid_q <= commit;
            if (commit) begin
                of_q <= c_of;
                zf_q <= (c_res == '0);
                // Destinations beyond the last bank update flags only.
                for (int unsigned k = 0; k < NUM_OUT; k++) begin
                    if (c_dest == 2'(k)) bank_q[k] <= c_res;
                end
            end
`ifdef ALU_MUL_EN
            case (state_q)
                StIdle: begin
                    if (accept && start_mul) begin
                        state_q <= StMul;
                        cnt_q   <= '0;
                        prod_q  <= {{WIDTH{1'b0}}, data1};
                        mcand_q <= data0;
                        mdest_q <= instruction[15:14];
                        mhi_q   <= instruction[10];
                    end
                end
                StMul: begin
                    prod_q <= prod_step;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (mul_done) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
`endif
        end
    end

    always_comb begin
        out_bank = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) out_bank[k*WIDTH +: WIDTH] = bank_q[k];
    end

    assign res_valid = res_valid_q;
    assign of        = of_q;
    assign zf        = zf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random traffic against a
// cycle-level reference model built from plain integer arithmetic.
module tb_alu_seq;

    localparam int W = 8;
    localparam int N = 4;
`ifdef ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [15:0]    instruction = '0;
    logic [W-1:0]   data0 = '0;
    logic [W-1:0]   data1 = '0;
    logic [N*W-1:0] out_bank;
    logic           res_valid;
    logic           of;
    logic           zf;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W), .NUM_OUT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruction(instruction),
        .data0      (data0),
        .data1      (data1),
        .out_bank   (out_bank),
        .res_valid  (res_valid),
        .of         (of),
        .zf         (zf)
    );

    always #5 clk = ~clk;

    // Reference state: banks, flags, and a countdown of busy cycles for a pending multiply.
    int m_bank [N];
    bit m_of, m_zf, m_rv;
    int m_busy;
    int p_dest, p_res;
    bit p_of;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_op(input logic [15:0] ins, input int a, input int b,
                                   output int r, output bit o, output bit mul);
        int g = int'(ins[13:12]);
        int op = int'(ins[11:10]);
        int p = a * b;
        r = 0;
        o = 1'b0;
        mul = 1'b0;
        case (g)
            0: begin
                if (op == 0) r = (b >= W) ? 0 : (a >> b);
                else if (op == 1) r = (b >= W) ? 0 : ((a << b) % (1 << W));
                else if (op == 2) begin
                    r = (a + b) % (1 << W);
                    o = (a + b) >= (1 << W);
                end else begin
                    r = (a - b + (1 << W)) % (1 << W);
                    o = a < b;
                end
            end
            1: begin
                if (op == 0) r = a & b;
                else if (op == 1) r = a | b;
                else if (op == 2) r = a ^ b;
                else r = 1;
            end
            2: begin
                if (MulEn && op < 2) begin
                    mul = 1'b1;
                    if (op == 0) begin
                        r = p % (1 << W);
                        o = p >= (1 << W);
                    end else begin
                        r = p / (1 << W);
                    end
                end
            end
            default: r = (a < b) ? 1 : 0;
        endcase
    endfunction

    task automatic model_commit(input int d, input int r, input bit o);
        if (d < N) m_bank[d] = r;
        m_of = o;
        m_zf = (r == 0);
        m_rv = 1'b1;
    endtask

    task automatic model_edge();
        int r;
        bit o, mul;
        m_rv = 1'b0;
        if (rst) begin
            for (int k = 0; k < N; k++) m_bank[k] = 0;
            m_of = 1'b0;
            m_zf = 1'b0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) model_commit(p_dest, p_res, p_of);
        end else if (in_valid) begin
            ref_op(instruction, int'(data0), int'(data1), r, o, mul);
            if (mul) begin
                m_busy = W;
                p_dest = int'(instruction[15:14]);
                p_res  = r;
                p_of   = o;
            end else begin
                model_commit(int'(instruction[15:14]), r, o);
            end
        end
    endtask

    task automatic step();
        logic [N*W-1:0] e;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < N; k++) e[k*W +: W] = W'(m_bank[k]);
        check("bank", 32'(out_bank), 32'(e));
        check("of", 32'(of), 32'(m_of));
        check("zf", 32'(zf), 32'(m_zf));
        check("res_valid", 32'(res_valid), 32'(m_rv));
        check("in_ready", 32'(in_ready), 32'(m_busy == 0));
    endtask

    task automatic apply(input bit r, input bit v, input logic [15:0] ins,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        rst = r;
        in_valid = v;
        instruction = ins;
        data0 = a;
        data1 = b;
        step();
    endtask

    initial begin
        // Reset for two cycles, then release.
        step();
        step();
        apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        check("rst_banks", 32'(out_bank), 32'h0);
        check("rst_flags", {30'b0, of, zf}, 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);

        // Add with carry into bank 2.
        apply(1'b0, 1'b1, 16'h8800, 8'hF0, 8'h20);
        check("add_bank2", 32'(out_bank[23:16]), 32'h10);
        check("add_of", 32'(of), 32'h1);
        check("add_rv", 32'(res_valid), 32'h1);
        apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        check("add_rv_drop", 32'(res_valid), 32'h0);

        // Back-to-back subtract and over-range shift.
        apply(1'b0, 1'b1, 16'h0C00, 8'h05, 8'h05);
        check("sub_zf", 32'(zf), 32'h1);
        apply(1'b0, 1'b1, 16'hC400, 8'hFF, 8'd9);
        check("shl_bank3", 32'(out_bank[31:24]), 32'h0);
        check("shl_rv", 32'(res_valid), 32'h1);
        apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);

        // Multiply low with in_valid held; one accept per idle window.
        for (int i = 0; i < 9; i++) apply(1'b0, 1'b1, 16'h6000, 8'h12, 8'h34);
        check("mul_lo_bank1", 32'(out_bank[15:8]), MulEn ? 32'hA8 : 32'h00);
        check("mul_lo_of", 32'(of), MulEn ? 32'h1 : 32'h0);
        check("mul_lo_rv", 32'(res_valid), 32'h1);
        apply(1'b0, 1'b1, 16'h6000, 8'h12, 8'h34);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);

        // Multiply high.
        apply(1'b0, 1'b1, 16'h6400, 8'hFF, 8'hFF);
        for (int i = 0; i < 9; i++) apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        check("mul_hi_bank1", 32'(out_bank[15:8]), MulEn ? 32'hFE : 32'h00);
        check("mul_hi_of", 32'(of), 32'h0);

        // Reset in the middle of a multiply.
        apply(1'b0, 1'b1, 16'h6000, 8'h12, 8'h34);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        apply(1'b1, 1'b0, 16'h0000, 8'h00, 8'h00);
        apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        check("abort_banks", 32'(out_bank), 32'h0);
        check("abort_rv", 32'(res_valid), 32'h0);
        check("abort_ready", 32'(in_ready), 32'h1);
        apply(1'b0, 1'b1, 16'h1C00, 8'h00, 8'h00);
        check("const1_bank0", 32'(out_bank[7:0]), 32'h01);
        apply(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);

        // Random traffic, with occasional resets and small shift amounts.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 16'($urandom),
                  8'($urandom),
                  ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
